// File: rtl/stg_wb.sv
// ============================================================================
// Module   : stg_wb
// Brief    : Amber write-back stage. Drives the GP/SR/AR write ports and splits
//            48-bit pair writes into two GP writes. Optional macro
//            AMBER_WB_FWD_EN adds registered bypass copies of the write ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef HBIT_ADDR
`define HBIT_ADDR 47
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif
`ifndef HBIT_OPC
`define HBIT_OPC 7
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif
`ifndef HBIT_TGT_SR
`define HBIT_TGT_SR 3
`endif
`ifndef HBIT_TGT_AR
`define HBIT_TGT_AR 3
`endif
`ifndef OPC_NOP
`define OPC_NOP 8'h00
`endif
`ifndef OPC_HALT
`define OPC_HALT 8'h3F
`endif

module stg_wb #(
    parameter int RETIRE_W     = 48,
    parameter int GP_PAIR_WRAP = 1
) (
    input  logic                    iw_clk,
    input  logic                    iw_rst,
    input  logic [`HBIT_ADDR:0]     iw_pc,
    input  logic [`HBIT_DATA:0]     iw_instr,
    input  logic [`HBIT_OPC:0]      iw_opc,
    input  logic [`HBIT_TGT_GP:0]   iw_tgt_gp,
    input  logic                    iw_tgt_gp_we,
    input  logic                    iw_tgt_gp_wide,
    input  logic [`HBIT_TGT_SR:0]   iw_tgt_sr,
    input  logic                    iw_tgt_sr_we,
    input  logic [`HBIT_TGT_AR:0]   iw_tgt_ar,
    input  logic                    iw_tgt_ar_we,
    input  logic [`HBIT_DATA:0]     iw_result,
    input  logic [`HBIT_ADDR:0]     iw_sr_result,
    input  logic [`HBIT_ADDR:0]     iw_ar_result,
    output logic                    ow_gp_we,
    output logic [`HBIT_TGT_GP:0]   ow_gp_addr,
    output logic [`HBIT_DATA:0]     ow_gp_wdata,
    output logic                    ow_sr_we,
    output logic [`HBIT_TGT_SR:0]   ow_sr_addr,
    output logic [`HBIT_ADDR:0]     ow_sr_wdata,
    output logic                    ow_ar_we,
    output logic [`HBIT_TGT_AR:0]   ow_ar_addr,
    output logic [`HBIT_ADDR:0]     ow_ar_wdata,
`ifdef AMBER_WB_FWD_EN
    output logic                    ow_fwd_gp_we,
    output logic [`HBIT_TGT_GP:0]   ow_fwd_gp_addr,
    output logic [`HBIT_DATA:0]     ow_fwd_gp_data,
    output logic                    ow_fwd_sr_we,
    output logic [`HBIT_TGT_SR:0]   ow_fwd_sr_addr,
    output logic [`HBIT_ADDR:0]     ow_fwd_sr_data,
    output logic                    ow_fwd_ar_we,
    output logic [`HBIT_TGT_AR:0]   ow_fwd_ar_addr,
    output logic [`HBIT_ADDR:0]     ow_fwd_ar_data,
`endif
    output logic                    ow_stall,
    output logic                    ow_halted,
    output logic [RETIRE_W-1:0]     ow_retired
);

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_HI   = 1'b1
    } wb_state_t;

    localparam logic [`HBIT_TGT_GP:0] c_GP_TOP   = '1;
    localparam logic [`HBIT_TGT_GP:0] c_GP_ONE   = {{`HBIT_TGT_GP{1'b0}}, 1'b1};
    localparam logic [RETIRE_W-1:0]   c_RET_ONE  = {{(RETIRE_W-1){1'b0}}, 1'b1};

    wb_state_t                r_state;
    logic                     r_halted;
    logic [RETIRE_W-1:0]      r_retired;
    logic                     r_hi_we;
    logic [`HBIT_TGT_GP:0]    r_hi_addr;
    logic [`HBIT_DATA:0]      r_hi_data;

    logic                     r_gp_we;
    logic [`HBIT_TGT_GP:0]    r_gp_addr;
    logic [`HBIT_DATA:0]      r_gp_wdata;
    logic                     r_sr_we;
    logic [`HBIT_TGT_SR:0]    r_sr_addr;
    logic [`HBIT_ADDR:0]      r_sr_wdata;
    logic                     r_ar_we;
    logic [`HBIT_TGT_AR:0]    r_ar_addr;
    logic [`HBIT_ADDR:0]      r_ar_wdata;

    logic w_bubble;
    logic w_unused_ok;

    // pc/instr travel with the bundle for debug visibility only
    assign w_unused_ok = &{1'b0, iw_pc, iw_instr};

    assign w_bubble = (iw_opc == `OPC_NOP) && !iw_tgt_gp_we
                      && !iw_tgt_sr_we && !iw_tgt_ar_we;

    always_ff @(posedge iw_clk) begin
        if (!iw_rst) begin
            r_state    <= WB_IDLE;
            r_halted   <= 1'b0;
            r_retired  <= '0;
            r_hi_we    <= 1'b0;
            r_hi_addr  <= '0;
            r_hi_data  <= '0;
            r_gp_we    <= 1'b0;
            r_gp_addr  <= '0;
            r_gp_wdata <= '0;
            r_sr_we    <= 1'b0;
            r_sr_addr  <= '0;
            r_sr_wdata <= '0;
            r_ar_we    <= 1'b0;
            r_ar_addr  <= '0;
            r_ar_wdata <= '0;
        end else begin
            r_gp_we <= 1'b0;
            r_sr_we <= 1'b0;
            r_ar_we <= 1'b0;
            case (r_state)
                WB_IDLE: begin
                    if (!r_halted) begin
                        if (iw_tgt_gp_we) begin
                            r_gp_we   <= 1'b1;
                            r_gp_addr <= iw_tgt_gp;
                            if (iw_tgt_gp_wide) begin
                                r_gp_wdata <= iw_ar_result[`HBIT_DATA:0];
                                r_hi_data  <= iw_ar_result[`HBIT_ADDR:`HBIT_DATA+1];
                                r_hi_addr  <= iw_tgt_gp + c_GP_ONE;
                                // top register: high half wraps to GP0 or is dropped
                                r_hi_we    <= (GP_PAIR_WRAP != 0) || (iw_tgt_gp != c_GP_TOP);
                                r_state    <= WB_HI;
                            end else begin
                                r_gp_wdata <= iw_result;
                            end
                        end
                        if (iw_tgt_sr_we) begin
                            r_sr_we    <= 1'b1;
                            r_sr_addr  <= iw_tgt_sr;
                            r_sr_wdata <= iw_sr_result;
                        end
                        if (iw_tgt_ar_we) begin
                            r_ar_we    <= 1'b1;
                            r_ar_addr  <= iw_tgt_ar;
                            r_ar_wdata <= iw_ar_result;
                        end
                        if (!w_bubble) begin
                            r_retired <= r_retired + c_RET_ONE;
                        end
                        if (iw_opc == `OPC_HALT) begin
                            r_halted <= 1'b1;
                        end
                    end
                end
                WB_HI: begin
                    r_gp_we    <= r_hi_we;
                    r_gp_addr  <= r_hi_addr;
                    r_gp_wdata <= r_hi_data;
                    r_state    <= WB_IDLE;
                end
                default: r_state <= WB_IDLE;
            endcase
        end
    end

    assign ow_gp_we    = r_gp_we;
    assign ow_gp_addr  = r_gp_addr;
    assign ow_gp_wdata = r_gp_wdata;
    assign ow_sr_we    = r_sr_we;
    assign ow_sr_addr  = r_sr_addr;
    assign ow_sr_wdata = r_sr_wdata;
    assign ow_ar_we    = r_ar_we;
    assign ow_ar_addr  = r_ar_addr;
    assign ow_ar_wdata = r_ar_wdata;
    assign ow_stall    = (r_state == WB_HI);
    assign ow_halted   = r_halted;
    assign ow_retired  = r_retired;

`ifdef AMBER_WB_FWD_EN
    always_ff @(posedge iw_clk) begin
        if (!iw_rst) begin
            ow_fwd_gp_we   <= 1'b0;
            ow_fwd_gp_addr <= '0;
            ow_fwd_gp_data <= '0;
            ow_fwd_sr_we   <= 1'b0;
            ow_fwd_sr_addr <= '0;
            ow_fwd_sr_data <= '0;
            ow_fwd_ar_we   <= 1'b0;
            ow_fwd_ar_addr <= '0;
            ow_fwd_ar_data <= '0;
        end else begin
            ow_fwd_gp_we   <= r_gp_we;
            ow_fwd_gp_addr <= r_gp_addr;
            ow_fwd_gp_data <= r_gp_wdata;
            ow_fwd_sr_we   <= r_sr_we;
            ow_fwd_sr_addr <= r_sr_addr;
            ow_fwd_sr_data <= r_sr_wdata;
            ow_fwd_ar_we   <= r_ar_we;
            ow_fwd_ar_addr <= r_ar_addr;
            ow_fwd_ar_data <= r_ar_wdata;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_stg_wb.sv
// ============================================================================
// Module   : tb_stg_wb
// Brief    : Directed self-checking bench for stg_wb (pair wrap on and off).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef HBIT_ADDR
`define HBIT_ADDR 47
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif
`ifndef HBIT_OPC
`define HBIT_OPC 7
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif
`ifndef HBIT_TGT_SR
`define HBIT_TGT_SR 3
`endif
`ifndef HBIT_TGT_AR
`define HBIT_TGT_AR 3
`endif
`ifndef OPC_NOP
`define OPC_NOP 8'h00
`endif
`ifndef OPC_HALT
`define OPC_HALT 8'h3F
`endif

module tb_stg_wb;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [`HBIT_ADDR:0]    pc;
    logic [`HBIT_DATA:0]    instr;
    logic [`HBIT_OPC:0]     opc;
    logic [`HBIT_TGT_GP:0]  tgt_gp;
    logic                   gp_we_in, gp_wide;
    logic [`HBIT_TGT_SR:0]  tgt_sr;
    logic                   sr_we_in;
    logic [`HBIT_TGT_AR:0]  tgt_ar;
    logic                   ar_we_in;
    logic [`HBIT_DATA:0]    result;
    logic [`HBIT_ADDR:0]    sr_result, ar_result;

    logic                   gp_we, sr_we, ar_we, stall, halted;
    logic [`HBIT_TGT_GP:0]  gp_addr;
    logic [`HBIT_DATA:0]    gp_wdata;
    logic [`HBIT_TGT_SR:0]  sr_addr;
    logic [`HBIT_ADDR:0]    sr_wdata;
    logic [`HBIT_TGT_AR:0]  ar_addr;
    logic [`HBIT_ADDR:0]    ar_wdata;
    logic [47:0]            retired;

    logic                   n_gp_we, n_sr_we, n_ar_we, n_stall, n_halted;
    logic [`HBIT_TGT_GP:0]  n_gp_addr;
    logic [`HBIT_DATA:0]    n_gp_wdata;
    logic [`HBIT_TGT_SR:0]  n_sr_addr;
    logic [`HBIT_ADDR:0]    n_sr_wdata;
    logic [`HBIT_TGT_AR:0]  n_ar_addr;
    logic [`HBIT_ADDR:0]    n_ar_wdata;
    logic [47:0]            n_retired;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stg_wb #(.RETIRE_W(48), .GP_PAIR_WRAP(1)) dut (
        .iw_clk(clk), .iw_rst(rst), .iw_pc(pc), .iw_instr(instr), .iw_opc(opc),
        .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(gp_we_in), .iw_tgt_gp_wide(gp_wide),
        .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(sr_we_in),
        .iw_tgt_ar(tgt_ar), .iw_tgt_ar_we(ar_we_in),
        .iw_result(result), .iw_sr_result(sr_result), .iw_ar_result(ar_result),
        .ow_gp_we(gp_we), .ow_gp_addr(gp_addr), .ow_gp_wdata(gp_wdata),
        .ow_sr_we(sr_we), .ow_sr_addr(sr_addr), .ow_sr_wdata(sr_wdata),
        .ow_ar_we(ar_we), .ow_ar_addr(ar_addr), .ow_ar_wdata(ar_wdata),
        .ow_stall(stall), .ow_halted(halted), .ow_retired(retired)
    );

    stg_wb #(.RETIRE_W(48), .GP_PAIR_WRAP(0)) dut_nowrap (
        .iw_clk(clk), .iw_rst(rst), .iw_pc(pc), .iw_instr(instr), .iw_opc(opc),
        .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(gp_we_in), .iw_tgt_gp_wide(gp_wide),
        .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(sr_we_in),
        .iw_tgt_ar(tgt_ar), .iw_tgt_ar_we(ar_we_in),
        .iw_result(result), .iw_sr_result(sr_result), .iw_ar_result(ar_result),
        .ow_gp_we(n_gp_we), .ow_gp_addr(n_gp_addr), .ow_gp_wdata(n_gp_wdata),
        .ow_sr_we(n_sr_we), .ow_sr_addr(n_sr_addr), .ow_sr_wdata(n_sr_wdata),
        .ow_ar_we(n_ar_we), .ow_ar_addr(n_ar_addr), .ow_ar_wdata(n_ar_wdata),
        .ow_stall(n_stall), .ow_halted(n_halted), .ow_retired(n_retired)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        opc = `OPC_NOP; gp_we_in = 1'b0; gp_wide = 1'b0;
        sr_we_in = 1'b0; ar_we_in = 1'b0;
    endtask

    initial begin
        rst = 1'b0; pc = '0; instr = '0; bubble();
        tgt_gp = '0; tgt_sr = '0; tgt_ar = '0;
        result = '0; sr_result = '0; ar_result = '0;

        // reset held with a live bundle
        opc = 8'h05; gp_we_in = 1'b1; tgt_gp = 4'd3; result = 24'h111111;
        sr_we_in = 1'b1; ar_we_in = 1'b1;
        tick(); tick();
        check("rst_gp_we", {63'd0, gp_we}, 64'd0);
        check("rst_sr_we", {63'd0, sr_we}, 64'd0);
        check("rst_ar_we", {63'd0, ar_we}, 64'd0);
        check("rst_retired", {16'd0, retired}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_gp_addr", {60'd0, gp_addr}, 64'd0);

        // narrow GP write
        rst = 1'b1; bubble();
        opc = 8'h05; gp_we_in = 1'b1; tgt_gp = 4'd3; result = 24'hABCDEF;
        tick();
        check("nar_gp_we", {63'd0, gp_we}, 64'd1);
        check("nar_gp_addr", {60'd0, gp_addr}, 64'd3);
        check("nar_gp_wdata", {40'd0, gp_wdata}, 64'hABCDEF);
        check("nar_retired", {16'd0, retired}, 64'd1);
        check("nar_sr_we", {63'd0, sr_we}, 64'd0);
        bubble();
        tick();
        check("bub_gp_we", {63'd0, gp_we}, 64'd0);
        check("bub_retired", {16'd0, retired}, 64'd1);

        // wide GP pair, bundle held through the stall cycle
        opc = 8'h06; gp_we_in = 1'b1; gp_wide = 1'b1; tgt_gp = 4'd4;
        ar_result = 48'hCAFEBE_987654;
        tick();
        check("wide1_gp_we", {63'd0, gp_we}, 64'd1);
        check("wide1_addr", {60'd0, gp_addr}, 64'd4);
        check("wide1_wdata", {40'd0, gp_wdata}, 64'h987654);
        check("wide1_stall", {63'd0, stall}, 64'd1);
        check("wide1_retired", {16'd0, retired}, 64'd2);
        tick();
        check("wide2_gp_we", {63'd0, gp_we}, 64'd1);
        check("wide2_addr", {60'd0, gp_addr}, 64'd5);
        check("wide2_wdata", {40'd0, gp_wdata}, 64'hCAFEBE);
        check("wide2_stall", {63'd0, stall}, 64'd0);
        check("wide2_retired", {16'd0, retired}, 64'd2);
        bubble();
        tick();
        check("wide3_gp_we", {63'd0, gp_we}, 64'd0);
        check("wide3_retired", {16'd0, retired}, 64'd2);

        // parallel SR + AR write
        opc = 8'h07; sr_we_in = 1'b1; tgt_sr = 4'd1; sr_result = 48'h123456_789ABC;
        ar_we_in = 1'b1; tgt_ar = 4'd2; ar_result = 48'h000014_000000;
        tick();
        check("par_sr_we", {63'd0, sr_we}, 64'd1);
        check("par_sr_addr", {60'd0, sr_addr}, 64'd1);
        check("par_sr_wdata", {16'd0, sr_wdata}, 64'h123456_789ABC);
        check("par_ar_we", {63'd0, ar_we}, 64'd1);
        check("par_ar_addr", {60'd0, ar_addr}, 64'd2);
        check("par_ar_wdata", {16'd0, ar_wdata}, 64'h000014_000000);
        check("par_gp_we", {63'd0, gp_we}, 64'd0);
        check("par_retired", {16'd0, retired}, 64'd3);
        bubble();
        tick();

        // pair at the top GP index: wrap vs drop
        opc = 8'h06; gp_we_in = 1'b1; gp_wide = 1'b1; tgt_gp = 4'd15;
        ar_result = 48'h111111_222222;
        tick();
        check("top1_addr", {60'd0, gp_addr}, 64'd15);
        check("top1_wdata", {40'd0, gp_wdata}, 64'h222222);
        check("top1_nw_gp_we", {63'd0, n_gp_we}, 64'd1);
        tick();
        check("wrap_gp_we", {63'd0, gp_we}, 64'd1);
        check("wrap_addr", {60'd0, gp_addr}, 64'd0);
        check("wrap_wdata", {40'd0, gp_wdata}, 64'h111111);
        check("nowrap_gp_we", {63'd0, n_gp_we}, 64'd0);
        check("nowrap_stall", {63'd0, n_stall}, 64'd0);
        check("nowrap_retired", {16'd0, n_retired}, 64'd4);
        bubble();
        tick();

        // reset taken while in WB_HI
        opc = 8'h06; gp_we_in = 1'b1; gp_wide = 1'b1; tgt_gp = 4'd6;
        ar_result = 48'hAAAAAA_BBBBBB;
        tick();
        check("hirst1_addr", {60'd0, gp_addr}, 64'd6);
        check("hirst1_stall", {63'd0, stall}, 64'd1);
        check("hirst1_retired", {16'd0, retired}, 64'd5);
        rst = 1'b0; bubble();
        tick();
        check("hirst2_gp_we", {63'd0, gp_we}, 64'd0);
        check("hirst2_stall", {63'd0, stall}, 64'd0);
        check("hirst2_retired", {16'd0, retired}, 64'd0);
        rst = 1'b1;
        tick();
        check("hirst3_gp_we", {63'd0, gp_we}, 64'd0);

        // HALT then a GP write that must be ignored
        opc = `OPC_HALT;
        tick();
        check("halt_halted", {63'd0, halted}, 64'd1);
        check("halt_retired", {16'd0, retired}, 64'd1);
        opc = 8'h05; gp_we_in = 1'b1; tgt_gp = 4'd7; result = 24'h555555;
        tick();
        check("post_halt_gp_we", {63'd0, gp_we}, 64'd0);
        check("post_halt_retired", {16'd0, retired}, 64'd1);
        tick();
        check("post_halt2_gp_we", {63'd0, gp_we}, 64'd0);
        check("post_halt2_halted", {63'd0, halted}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
